// File: rtl/serial_pkg.sv
// Shared definitions for the serial byte link: FSM states, frame levels
// and the 7-segment decoder used by both transmitter and receiver.
package serial_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } tx_state_t;

  localparam int   DATA_BITS = 8;
  localparam logic START_LVL = 1'b0;
  localparam logic STOP_LVL  = 1'b1;

  // Active-low 7-segment pattern, bit order {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b1000000;
      4'h1:    seg = 7'b1111001;
      4'h2:    seg = 7'b0100100;
      4'h3:    seg = 7'b0110000;
      4'h4:    seg = 7'b0011001;
      4'h5:    seg = 7'b0010010;
      4'h6:    seg = 7'b0000010;
      4'h7:    seg = 7'b1111000;
      4'h8:    seg = 7'b0000000;
      4'h9:    seg = 7'b0010000;
      4'hA:    seg = 7'b0001000;
      4'hB:    seg = 7'b0000011;
      4'hC:    seg = 7'b1000110;
      4'hD:    seg = 7'b0100001;
      4'hE:    seg = 7'b0000110;
      4'hF:    seg = 7'b0001110;
      default: seg = 7'b1111111;
    endcase
    return seg;
  endfunction

endpackage

// File: rtl/key_edge.sv
// Two-flop synchronizer for a raw active-low key, producing a one-clock
// pulse when the key is pressed (synchronized falling edge).
module key_edge (
  input  logic clk,
  input  logic reset,
  input  logic key,
  output logic push
);

  logic newer_r;
  logic older_r;

  // Synchronizer chain; resets to the released level so reset never fakes a press.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      newer_r <= 1'b1;
      older_r <= 1'b1;
    end else begin
      newer_r <= key;
      older_r <= newer_r;
    end
  end

  assign push = older_r & ~newer_r;

endmodule

// File: rtl/serial_byte_tx.sv
// Framed serial transmitter: start bit, 8 data bits LSB first, stop bit,
// each held for CLK_DIV clocks. Byte comes from a hold register loaded
// from the switches; LEDs and two HEX digits show status.
module serial_byte_tx
  import serial_pkg::*;
#(
  parameter int CLK_DIV = 50000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        KEY_LOAD,
  input  logic        KEY_SEND,
  input  logic [7:0]  SW,
  output logic        TX,
  output logic        BUSY,
  output logic [15:0] LED,
  output logic [6:0]  HEX0,
  output logic [6:0]  HEX1
);

  localparam int                BAUD_W    = $clog2(CLK_DIV);
  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLK_DIV - 1);
  localparam logic [3:0]        LAST_BIT  = 4'(DATA_BITS - 1);

  tx_state_t         state_r, state_s;
  logic [BAUD_W-1:0] baud_r, baud_s;
  logic [7:0]        shift_r, shift_s;
  logic [7:0]        hold_r, hold_s;
  logic [3:0]        bit_idx_r, bit_idx_s;
  logic              tx_r, tx_s;
  logic              busy_r, busy_s;
  logic              load_push_s;
  logic              send_push_s;
  logic              wrap_s;

  key_edge u_load_edge (
    .clk   (clk),
    .reset (reset),
    .key   (KEY_LOAD),
    .push  (load_push_s)
  );

  key_edge u_send_edge (
    .clk   (clk),
    .reset (reset),
    .key   (KEY_SEND),
    .push  (send_push_s)
  );

  // Next-state, datapath updates and next output levels for the frame FSM.
  always_comb begin
    wrap_s    = (baud_r == BAUD_LAST);
    state_s   = state_r;
    shift_s   = shift_r;
    hold_s    = hold_r;
    bit_idx_s = bit_idx_r;
    baud_s    = wrap_s ? {BAUD_W{1'b0}} : baud_r + BAUD_W'(1);
    tx_s      = STOP_LVL;

    case (state_r)
      IDLE: begin
        baud_s = {BAUD_W{1'b0}};
        // Load has priority; a send in the same cycle is dropped.
        if (load_push_s) begin
          hold_s  = SW;
          shift_s = SW;
        end else if (send_push_s) begin
          shift_s   = hold_r;
          bit_idx_s = 4'd0;
          state_s   = START;
        end else begin
          state_s = IDLE;
        end
      end
      START: begin
        if (wrap_s) state_s = DATA;
        else        state_s = START;
      end
      DATA: begin
        if (wrap_s) begin
          shift_s   = {1'b0, shift_r[7:1]};
          bit_idx_s = bit_idx_r + 4'd1;
          if (bit_idx_r == LAST_BIT) state_s = STOP;
          else                       state_s = DATA;
        end else begin
          state_s = DATA;
        end
      end
      STOP: begin
        if (wrap_s) state_s = IDLE;
        else        state_s = STOP;
      end
      default: begin
        state_s = IDLE;
      end
    endcase

    // Every state entry starts a fresh bit period.
    if (state_s != state_r) baud_s = {BAUD_W{1'b0}};
    else                    baud_s = baud_s;

    case (state_s)
      IDLE:    tx_s = STOP_LVL;
      START:   tx_s = START_LVL;
      DATA:    tx_s = shift_s[0];
      STOP:    tx_s = STOP_LVL;
      default: tx_s = STOP_LVL;
    endcase
    busy_s = (state_s != IDLE);
  end

  // State, datapath and registered line outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      baud_r    <= {BAUD_W{1'b0}};
      shift_r   <= 8'h00;
      hold_r    <= 8'h00;
      bit_idx_r <= 4'd0;
      tx_r      <= 1'b1;
      busy_r    <= 1'b0;
    end else begin
      state_r   <= state_s;
      baud_r    <= baud_s;
      shift_r   <= shift_s;
      hold_r    <= hold_s;
      bit_idx_r <= bit_idx_s;
      tx_r      <= tx_s;
      busy_r    <= busy_s;
    end
  end

  assign TX   = tx_r;
  assign BUSY = busy_r;
  assign LED  = {bit_idx_r, 4'b0000, shift_r};
  assign HEX0 = hex7(hold_r[3:0]);
  assign HEX1 = hex7(hold_r[7:4]);

endmodule

// File: tb/tb_serial_byte_tx.sv
// Directed bench for serial_byte_tx with CLK_DIV=4: table of load/send
// vectors plus hand-written sequences for mid-frame, reset and
// back-to-back corner cases.
module tb_serial_byte_tx;

  localparam int DIV = 4;

  logic        clk;
  logic        reset;
  logic        KEY_LOAD;
  logic        KEY_SEND;
  logic [7:0]  SW;
  logic        TX;
  logic        BUSY;
  logic [15:0] LED;
  logic [6:0]  HEX0;
  logic [6:0]  HEX1;

  int total;
  int bad;
  int w;

  serial_byte_tx #(.CLK_DIV(DIV)) dut (
    .clk      (clk),
    .reset    (reset),
    .KEY_LOAD (KEY_LOAD),
    .KEY_SEND (KEY_SEND),
    .SW       (SW),
    .TX       (TX),
    .BUSY     (BUSY),
    .LED      (LED),
    .HEX0     (HEX0),
    .HEX1     (HEX1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [7:0] sw;
    logic [6:0] hex1;
    logic [6:0] hex0;
    logic [0:9] seq;
  } vec_t;

  vec_t vecs [0:3];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", name, act, exp);
    end
  endtask

  task automatic press_send();
    KEY_SEND = 1'b0;
    repeat (3) @(negedge clk);
    KEY_SEND = 1'b1;
  endtask

  task automatic press_load();
    KEY_LOAD = 1'b0;
    repeat (3) @(negedge clk);
    KEY_LOAD = 1'b1;
    repeat (2) @(negedge clk);
  endtask

  // Wait for BUSY, record TX over the whole frame and compare.
  task automatic capture_frame(input string name, input logic [7:0] b, input logic [0:9] exp);
    logic samp [0:199];
    logic [0:9] got;
    int n;
    int t;
    logic stable;
    t = 0;
    while (BUSY !== 1'b1 && t < 20) begin
      @(negedge clk);
      t++;
    end
    check({name, "_busy_rise"}, {31'd0, BUSY}, 32'd1);
    check({name, "_led_start"}, {16'd0, LED}, {16'd0, 8'h00, b});
    n = 0;
    while (BUSY === 1'b1 && n < 200) begin
      samp[n] = TX;
      n++;
      @(negedge clk);
    end
    check({name, "_busy_len"}, n, 10 * DIV);
    stable = 1'b1;
    for (int j = 0; j < 10; j++) begin
      got[j] = (j * DIV < n) ? samp[j * DIV] : 1'bx;
      for (int m = 0; m < DIV; m++) begin
        if (j * DIV + m >= n || samp[j * DIV + m] !== got[j]) stable = 1'b0;
      end
    end
    check({name, "_bits"}, {22'd0, got}, {22'd0, exp});
    check({name, "_bit_hold"}, {31'd0, stable}, 32'd1);
  endtask

  task automatic expect_idle(input string name, input int cycles);
    int nb;
    nb = 0;
    for (int i = 0; i < cycles; i++) begin
      @(negedge clk);
      if (BUSY !== 1'b0) nb++;
    end
    check(name, nb, 0);
  endtask

  initial begin
    logic b2b [0:119];
    int busy_cnt;
    int rises;
    int gap;
    int first1;
    int last1;

    total    = 0;
    bad      = 0;
    reset    = 1'b1;
    KEY_LOAD = 1'b1;
    KEY_SEND = 1'b1;
    SW       = 8'h00;

    vecs[0] = '{sw: 8'hA5, hex1: 7'b0001000, hex0: 7'b0010010, seq: 10'b0101001011};
    vecs[1] = '{sw: 8'h3C, hex1: 7'b0110000, hex0: 7'b1000110, seq: 10'b0001111001};
    vecs[2] = '{sw: 8'hE2, hex1: 7'b0000110, hex0: 7'b0100100, seq: 10'b0010001111};
    vecs[3] = '{sw: 8'h9B, hex1: 7'b0010000, hex0: 7'b0000011, seq: 10'b0110110011};

    repeat (3) @(negedge clk);
    reset = 1'b0;

    // Reset state held with no keys.
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      check("rst_tx", {31'd0, TX}, 32'd1);
      check("rst_busy", {31'd0, BUSY}, 32'd0);
      check("rst_led", {16'd0, LED}, 32'h0000);
      check("rst_hex0", {25'd0, HEX0}, {25'd0, 7'b1000000});
      check("rst_hex1", {25'd0, HEX1}, {25'd0, 7'b1000000});
    end

    // Table: load a byte, check HEX, send and check the frame.
    for (int v = 0; v < 4; v++) begin
      SW = vecs[v].sw;
      press_load();
      check($sformatf("v%0d_hex1", v), {25'd0, HEX1}, {25'd0, vecs[v].hex1});
      check($sformatf("v%0d_hex0", v), {25'd0, HEX0}, {25'd0, vecs[v].hex0});
      fork
        press_send();
        capture_frame($sformatf("v%0d", v), vecs[v].sw, vecs[v].seq);
      join
      repeat (2) @(negedge clk);
    end

    // Mid-frame send and load are ignored.
    SW = 8'hA5;
    press_load();
    fork
      press_send();
      capture_frame("mid", 8'hA5, 10'b0101001011);
      begin
        w = 0;
        while (BUSY !== 1'b1 && w < 20) begin
          @(negedge clk);
          w++;
        end
        repeat (10) @(negedge clk);
        press_send();
        repeat (6) @(negedge clk);
        SW = 8'h3C;
        press_load();
      end
    join
    check("mid_hex1", {25'd0, HEX1}, {25'd0, 7'b0001000});
    check("mid_hex0", {25'd0, HEX0}, {25'd0, 7'b0010010});
    expect_idle("mid_no_second", 60);

    // Load and send in the same cycle: load wins, no frame.
    SW = 8'h0F;
    fork
      begin
        KEY_LOAD = 1'b0;
        KEY_SEND = 1'b0;
        repeat (3) @(negedge clk);
        KEY_LOAD = 1'b1;
        KEY_SEND = 1'b1;
      end
      expect_idle("both_no_frame", 60);
    join
    check("both_hex1", {25'd0, HEX1}, {25'd0, 7'b1000000});
    check("both_hex0", {25'd0, HEX0}, {25'd0, 7'b0001110});
    fork
      press_send();
      capture_frame("both_send", 8'h0F, 10'b0111100001);
    join
    repeat (2) @(negedge clk);

    // Async reset during data bit 4.
    fork
      press_send();
      begin
        w = 0;
        while (BUSY !== 1'b1 && w < 20) begin
          @(negedge clk);
          w++;
        end
        repeat (21) @(negedge clk);
        #1 reset = 1'b1;
        #1;
        check("arst_tx", {31'd0, TX}, 32'd1);
        check("arst_busy", {31'd0, BUSY}, 32'd0);
        check("arst_led", {16'd0, LED}, 32'h0000);
        check("arst_hex0", {25'd0, HEX0}, {25'd0, 7'b1000000});
        check("arst_hex1", {25'd0, HEX1}, {25'd0, 7'b1000000});
        @(negedge clk);
        reset = 1'b0;
      end
    join
    expect_idle("arst_no_spurious", 10);
    fork
      press_send();
      capture_frame("after_rst", 8'h00, 10'b0000000001);
    join
    repeat (2) @(negedge clk);

    // Back-to-back: second push lands on the first idle cycle.
    fork
      press_send();
      begin
        repeat (41) @(negedge clk);
        press_send();
      end
      begin
        for (int i = 0; i < 120; i++) begin
          @(negedge clk);
          b2b[i] = BUSY;
        end
      end
    join
    busy_cnt = 0;
    rises    = 0;
    first1   = -1;
    last1    = -1;
    for (int i = 0; i < 120; i++) begin
      if (b2b[i] === 1'b1) begin
        busy_cnt++;
        if (first1 < 0) first1 = i;
        last1 = i;
        if (i == 0 || b2b[i-1] !== 1'b1) rises++;
      end
    end
    gap = (first1 >= 0) ? (last1 - first1 + 1 - busy_cnt) : -1;
    check("b2b_busy_total", busy_cnt, 80);
    check("b2b_rises", rises, 2);
    check("b2b_gap", gap, 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/serial_byte_tx.md
# serial_byte_tx

Serial transmitter for the board-level shift-register link. Takes an 8-bit value from the switches and shifts it out on a single line as a framed serial stream, one bit per `CLK_DIV` clocks. The frame is a start bit, 8 data bits LSB first, then a stop bit. A 16-bit shift-in receiver sampling `TX` recovers the byte. The block sits between the key/switch inputs and the serial output pin, and drives LEDs and two HEX digits for status.

## Interface
- `CLK_DIV`, default 50000: clock cycles per bit period; legal range ≥ 2.
- `clk` input 1: system clock.
- `reset` input 1: one clock; reset is asynchronous and active-high.
- `KEY_LOAD` input 1: raw active-low button; a falling edge latches `SW` into the hold register.
- `KEY_SEND` input 1: raw active-low button; a falling edge starts a frame.
- `SW` input 8: byte to load.
- `TX` output 1: serial line, registered; idles high.
- `BUSY` output 1: high while a frame is on the line.
- `LED` output 16: `{bit_index[3:0], 4'b0, shift_reg[7:0]}`.
- `HEX0` output 7: hold register low nibble, 7-segment active-low, 0→`1000000` … F→`0001110`.
- `HEX1` output 7: hold register high nibble, same encoding.

## Operation
- Each key passes through a 2-flop synchronizer. The push pulse is `older & ~newer`: one clock wide per press, with no debounce beyond that.
- FSM states:
  - IDLE: `TX`=1, `BUSY`=0.
  - START: `TX`=0.
  - DATA: `TX`=`shift_reg[0]`.
  - STOP: `TX`=1.
- IDLE transitions:
  - Load push loads `hold` and `shift_reg` from `SW`.
  - Send push copies `hold` into `shift_reg`, clears `bit_index`, and moves to START.
  - Load and send pushes in the same cycle: load wins and the send push is dropped.
- START → DATA after `CLK_DIV` cycles.
- DATA: each `CLK_DIV` cycles, shift `shift_reg` right by 1 (MSB filled with 0) and increment `bit_index`. After the 8th bit period (`bit_index`=7 expiring) move to STOP.
- STOP → IDLE after `CLK_DIV` cycles.
- While `BUSY`=1, load and send pushes are ignored. `hold` and the HEX digits do not change mid-frame.
- Baud counter:
  - Width is `$clog2(CLK_DIV)`.
  - Cleared on every state entry; counts 0..`CLK_DIV`-1.
  - Wrap is a bit-period boundary.
- Async reset at any time, including mid-frame:
  - Immediately: `TX`=1, `BUSY`=0, state IDLE.
  - `hold`, `shift_reg`, `bit_index` and the baud counter go to 0, so `LED`=0 and HEX0/HEX1=`1000000`.
  - Synchronizer flops reset to 1 (released key level), so no spurious push occurs after reset.

## Timing
- Key falling edge to push pulse: 2 clocks.
- Push at edge N: at edge N the state leaves IDLE, and `TX` falls and `BUSY` rises in the cycle after edge N.
- Bit k (k=0..7) occupies cycles N+1+(k+1)·`CLK_DIV` … N+(k+2)·`CLK_DIV`.
- Stop bit ends and `BUSY` drops after edge N+10·`CLK_DIV`.
- Frame length: exactly 10·`CLK_DIV` cycles.
- A back-to-back send is accepted on the first cycle `BUSY`=0.
- HEX outputs are combinational from `hold`. They update one clock after the load push.

## Structure
- Shared package `serial_pkg`:
  - FSM state enum (IDLE/START/DATA/STOP).
  - Frame constants: `DATA_BITS`=8, `START_LVL`=0, `STOP_LVL`=1.
  - The 7-segment hex decode function, shared with the receiver side.
- One sub-module `key_edge`: 2-flop synchronizer plus falling-edge pulse, instantiated twice.
- The FSM, baud counter and shift register live in the top module.

## Test plan
- Reset release, no keys → `TX`=1, `BUSY`=0, `LED`=0x0000, HEX0=HEX1=`1000000` for 100 cycles.
- `CLK_DIV`=4, `SW`=0xA5, press LOAD then SEND:
  - HEX1=`0001000`, HEX0=`0010010`.
  - `TX` sequence 0,1,0,1,0,0,1,0,1,1, each bit held 4 cycles.
  - `BUSY` high exactly 40 cycles.
- SEND pressed mid-frame, and LOAD with `SW`=0x3C mid-frame → frame unchanged, `hold` stays 0xA5, no second frame.
- LOAD and SEND pulses in the same cycle in IDLE with `SW`=0x0F → `hold`=0x0F, no frame starts. A subsequent SEND transmits 0x0F.
- Async `reset` asserted during data bit 4 → `TX`=1 and `BUSY`=0 before the next clock edge, all registers 0. A following SEND transmits 0x00.
- Two SENDs timed so the second push lands on the first idle cycle → second frame starts with no gap beyond that cycle, total 80 busy cycles.
